// File: rtl/burst_error_channel.sv
// burst_error_channel: registered noisy-channel model placed between a
// convolutional encoder and a Viterbi decoder. Each valid W-bit symbol is
// passed through with one cycle of latency. While enabled, BURST_LEN
// consecutive valid symbols in every PERIOD are XORed with ERR_MASK, starting
// at phase OFFSET. Counts of symbols and flipped bits stop growing once
// sym_ct reaches MAX_SYMS.
// Optional feature: define CHAN_LFSR_EN to add pseudo-random single-symbol
// errors in the gap between bursts. A symbol is corrupted when LFSR[7:0] < THRESH.
module burst_error_channel #(
  parameter int             W         = 2,
  parameter int             PERIOD    = 8,
  parameter int             OFFSET    = 1,
  parameter int             BURST_LEN = 3,
  parameter logic [W-1:0]   ERR_MASK  = W'(2'b10),
  parameter int             CT_W      = 16,
  parameter int             MAX_SYMS  = 256,
  parameter logic [7:0]     THRESH    = 8'd16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clear_i,
  input  logic            valid_i,
  input  logic [W-1:0]    d_i,
  output logic            valid_o,
  output logic [W-1:0]    d_o,
  output logic [W-1:0]    err_o,
  output logic            burst_o,
  output logic [CT_W-1:0] sym_ct,
  output logic [CT_W-1:0] bad_bit_ct
);

  // Number of ones in the mask, i.e. bits flipped per corrupted symbol.
  function automatic int popcount(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  localparam int P_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int L_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [P_W-1:0]  OFFSET_P    = P_W'(OFFSET);
  localparam logic [P_W-1:0]  PERIOD_LAST = P_W'(PERIOD - 1);
  localparam logic [L_W-1:0]  LEFT_RELOAD = L_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
  localparam logic            BURST_EN    = (BURST_LEN > 0);
  localparam logic [CT_W-1:0] MASK_BITS   = CT_W'(popcount(ERR_MASK));
  localparam logic [CT_W:0]   MAX_EXT     = (CT_W+1)'(MAX_SYMS);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    BURST
  } state_e;

  state_e          state_q, state_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [L_W-1:0]  left_q, left_d;
  logic            valid_q;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    err_q, err_d;
  logic [CT_W-1:0] sym_ct_q, sym_ct_d;
  logic [CT_W-1:0] bad_ct_q, bad_ct_d;

  logic            corrupt;
  logic            at_offset;
  logic            rand_hit;
  logic            below_max;
  logic [CT_W:0]   sym_sum;
  logic [CT_W:0]   bad_sum;

  assign at_offset = (p_q == OFFSET_P);

`ifdef CHAN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR (taps 16,14,13,11) stepping once per valid symbol.
  always_comb begin
    lfsr_d = lfsr_q;
    if (valid_i) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign rand_hit = (lfsr_q[7:0] < THRESH);
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign rand_hit      = 1'b0;
`endif

  // Burst FSM: phase tracking, burst length countdown and the corrupt decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    p_d     = p_q;
    left_d  = left_q;
    corrupt = 1'b0;
    if (!enable) begin
      // Dropping enable aborts any burst. The current symbol stays clean,
      // and the phase is re-armed for the next enable.
      state_d = IDLE;
      p_d     = '0;
      left_d  = '0;
    end else if (valid_i) begin
      p_d = (p_q == PERIOD_LAST) ? '0 : p_q + 1'b1;
      unique case (state_q)
        // IDLE with enable behaves as GAP at phase 0 (p_q is held at 0 in IDLE).
        IDLE, GAP: begin
          state_d = GAP;
          if (at_offset && BURST_EN) begin
            corrupt = 1'b1;
            left_d  = LEFT_RELOAD;
            if (LEFT_RELOAD != '0) state_d = BURST;
          end else if (rand_hit) begin
            corrupt = 1'b1;
          end
        end
        BURST: begin
          corrupt = 1'b1;
          // Hitting the burst phase again restarts the count, so
          // BURST_LEN >= PERIOD gives continuous corruption.
          left_d  = at_offset ? LEFT_RELOAD : left_q - 1'b1;
          state_d = (left_d == '0) ? GAP : BURST;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Data path: apply the mask on valid symbols and hold the outputs otherwise.
  always_comb begin
    err_d = err_q;
    d_d   = d_q;
    if (valid_i) begin
      err_d = corrupt ? ERR_MASK : '0;
      d_d   = d_i ^ err_d;
    end
  end

  // Statistics: counters saturate, freeze at MAX_SYMS, and clear takes priority.
  always_comb begin
    below_max = ({1'b0, sym_ct_q} < MAX_EXT);
    sym_sum   = {1'b0, sym_ct_q} + 1'b1;
    bad_sum   = {1'b0, bad_ct_q} + (corrupt ? {1'b0, MASK_BITS} : '0);
    sym_ct_d  = sym_ct_q;
    bad_ct_d  = bad_ct_q;
    if (clear_i) begin
      sym_ct_d = '0;
      bad_ct_d = '0;
    end else if (valid_i && below_max) begin
      sym_ct_d = sym_sum[CT_W] ? '1 : sym_sum[CT_W-1:0];
      bad_ct_d = bad_sum[CT_W] ? '1 : bad_sum[CT_W-1:0];
    end
  end

  // State and output registers. Reset drops any in-flight symbol.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments, so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      left_q   <= '0;
      valid_q  <= 1'b0;
      d_q      <= '0;
      err_q    <= '0;
      sym_ct_q <= '0;
      bad_ct_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      left_q   <= left_d;
      valid_q  <= valid_i;
      d_q      <= d_d;
      err_q    <= err_d;
      sym_ct_q <= sym_ct_d;
      bad_ct_q <= bad_ct_d;
    end
  end

  assign valid_o    = valid_q;
  assign d_o        = d_q;
  assign err_o      = err_q;
  assign burst_o    = (state_q == BURST);
  assign sym_ct     = sym_ct_q;
  assign bad_bit_ct = bad_ct_q;

endmodule

// File: tb/tb_burst_error_channel.sv
// Directed bench for burst_error_channel. Three instances share one stimulus:
// the default configuration, BURST_LEN=0 (never inject) and BURST_LEN=10
// (continuous corruption). The stimulus is a hand-computed vector table
// followed by sequences for clear, reset mid-burst and statistics freeze.
module tb_burst_error_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_i;
  logic        valid_i;
  logic [1:0]  d_i;

  logic        a_valid_o, z_valid_o, c_valid_o;
  logic [1:0]  a_d_o, z_d_o, c_d_o;
  logic [1:0]  a_err_o, z_err_o, c_err_o;
  logic        a_burst_o, z_burst_o, c_burst_o;
  logic [15:0] a_sym_ct, z_sym_ct, c_sym_ct;
  logic [15:0] a_bad_ct, z_bad_ct, c_bad_ct;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  burst_error_channel dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear_i(clear_i), .valid_i(valid_i), .d_i(d_i),
    .valid_o(a_valid_o), .d_o(a_d_o), .err_o(a_err_o), .burst_o(a_burst_o),
    .sym_ct(a_sym_ct), .bad_bit_ct(a_bad_ct)
  );

  burst_error_channel #(.BURST_LEN(0)) dut_z (
    .clk(clk), .rst(rst), .enable(enable), .clear_i(clear_i), .valid_i(valid_i), .d_i(d_i),
    .valid_o(z_valid_o), .d_o(z_d_o), .err_o(z_err_o), .burst_o(z_burst_o),
    .sym_ct(z_sym_ct), .bad_bit_ct(z_bad_ct)
  );

  burst_error_channel #(.BURST_LEN(10)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .clear_i(clear_i), .valid_i(valid_i), .d_i(d_i),
    .valid_o(c_valid_o), .d_o(c_d_o), .err_o(c_err_o), .burst_o(c_burst_o),
    .sym_ct(c_sym_ct), .bad_bit_ct(c_bad_ct)
  );

  typedef struct {
    logic       vi;
    logic       en;
    logic [1:0] d;
    logic       ev;
    logic [1:0] ed;
    logic [1:0] ee;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vi, input logic en, input logic [1:0] d,
                     input logic ev, input logic [1:0] ed, input logic [1:0] ee,
                     input logic eb);
    vec_t v;
    v.vi = vi; v.en = en; v.d = d; v.ev = ev; v.ed = ed; v.ee = ee; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic vi, input logic en, input logic clr, input logic [1:0] d);
    valid_i = vi;
    enable  = en;
    clear_i = clr;
    d_i     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] z_exp;

    // A: enable=1, valid every cycle; bursts on symbols 1-3 and 9-11.
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b01, 1,2'b11,2'b10,1);
    add(1,1,2'b10, 1,2'b00,2'b10,1);
    add(1,1,2'b11, 1,2'b01,2'b10,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b01, 1,2'b01,2'b00,0);
    add(1,1,2'b10, 1,2'b10,2'b00,0);
    add(1,1,2'b11, 1,2'b11,2'b00,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b01, 1,2'b11,2'b10,1);
    add(1,1,2'b10, 1,2'b00,2'b10,1);
    add(1,1,2'b11, 1,2'b01,2'b10,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b01, 1,2'b01,2'b00,0);
    add(1,1,2'b10, 1,2'b10,2'b00,0);
    add(1,1,2'b11, 1,2'b11,2'b00,0);
    // B: valid toggling; burst lands on valid symbols 1-3, outputs hold on gaps.
    add(1,1,2'b11, 1,2'b11,2'b00,0);
    add(0,1,2'b00, 0,2'b11,2'b00,0);
    add(1,1,2'b11, 1,2'b01,2'b10,1);
    add(0,1,2'b01, 0,2'b01,2'b10,1);
    add(1,1,2'b00, 1,2'b10,2'b10,1);
    add(0,1,2'b00, 0,2'b10,2'b10,1);
    add(1,1,2'b01, 1,2'b11,2'b10,0);
    add(0,1,2'b00, 0,2'b11,2'b10,0);
    add(1,1,2'b10, 1,2'b10,2'b00,0);
    add(0,1,2'b11, 0,2'b10,2'b00,0);
    // C: phases 5,6,7,0 clean, burst at 1,2, enable drops on the 3rd symbol.
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b00, 1,2'b10,2'b10,1);
    add(1,1,2'b01, 1,2'b11,2'b10,1);
    add(1,0,2'b01, 1,2'b01,2'b00,0);
    add(1,0,2'b10, 1,2'b10,2'b00,0);
    // Re-enable: the burst starts at the 2nd valid symbol after enable.
    add(1,1,2'b00, 1,2'b00,2'b00,0);
    add(1,1,2'b00, 1,2'b10,2'b10,1);
    add(1,1,2'b00, 1,2'b10,2'b10,1);
    add(1,1,2'b00, 1,2'b10,2'b10,0);
    add(1,1,2'b00, 1,2'b00,2'b00,0);

    rst = 1'b1; enable = 1'b0; clear_i = 1'b0; valid_i = 1'b0; d_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst a_valid_o", 32'(a_valid_o), 0);
    check("rst a_d_o",     32'(a_d_o), 0);
    check("rst a_err_o",   32'(a_err_o), 0);
    check("rst a_burst_o", 32'(a_burst_o), 0);
    check("rst a_sym_ct",  32'(a_sym_ct), 0);
    check("rst a_bad_ct",  32'(a_bad_ct), 0);
    check("rst z_d_o",     32'(z_d_o), 0);
    check("rst c_valid_o", 32'(c_valid_o), 0);
    check("rst c_burst_o", 32'(c_burst_o), 0);
    rst = 1'b0;

    z_exp = 2'b00;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vi, vecs[i].en, 1'b0, vecs[i].d);
      check($sformatf("vec%0d valid_o", i), 32'(a_valid_o), 32'(vecs[i].ev));
      check($sformatf("vec%0d d_o", i),     32'(a_d_o),     32'(vecs[i].ed));
      check($sformatf("vec%0d err_o", i),   32'(a_err_o),   32'(vecs[i].ee));
      check($sformatf("vec%0d burst_o", i), 32'(a_burst_o), 32'(vecs[i].eb));
      if (vecs[i].vi) z_exp = vecs[i].d;
      check($sformatf("vec%0d bl0 d_o", i), 32'(z_d_o), 32'(z_exp));
      check($sformatf("vec%0d bl0 burst_o", i), 32'(z_burst_o), 0);
      if (i < 16)
        check($sformatf("vec%0d bl10 err_o", i), 32'(c_err_o), (i >= 1) ? 32'h2 : 32'h0);
    end
    check("table sym_ct", 32'(a_sym_ct), 34);
    check("table bad_bit_ct", 32'(a_bad_ct), 14);
    check("table bl0 sym_ct", 32'(z_sym_ct), 34);
    check("table bl0 bad_bit_ct", 32'(z_bad_ct), 0);

    // clear_i alone, then clear_i together with a valid symbol (clear wins).
    step(1'b0, 1'b0, 1'b1, 2'b00);
    check("clear sym_ct", 32'(a_sym_ct), 0);
    check("clear bad_bit_ct", 32'(a_bad_ct), 0);
    step(1'b1, 1'b0, 1'b1, 2'b01);
    check("clear prio sym_ct", 32'(a_sym_ct), 0);
    check("clear prio d_o", 32'(a_d_o), 32'h1);
    check("clear prio err_o", 32'(a_err_o), 0);

    // Reset in the middle of a burst.
    step(1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00);
    check("pre-rst burst_o", 32'(a_burst_o), 1);
    check("pre-rst err_o", 32'(a_err_o), 32'h2);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'b11);
    check("mid-burst rst valid_o", 32'(a_valid_o), 0);
    check("mid-burst rst d_o", 32'(a_d_o), 0);
    check("mid-burst rst err_o", 32'(a_err_o), 0);
    check("mid-burst rst burst_o", 32'(a_burst_o), 0);
    check("mid-burst rst sym_ct", 32'(a_sym_ct), 0);
    check("mid-burst rst bad_bit_ct", 32'(a_bad_ct), 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 2'b00);
    check("post-rst sym0 err_o", 32'(a_err_o), 0);
    check("post-rst sym0 burst_o", 32'(a_burst_o), 0);
    step(1'b1, 1'b1, 1'b0, 2'b00);
    check("post-rst sym1 err_o", 32'(a_err_o), 32'h2);
    check("post-rst sym1 burst_o", 32'(a_burst_o), 1);

    // 300 valid symbols from reset: statistics freeze at 256 / 96.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b0, 2'b00);
    check("freeze sym_ct", 32'(a_sym_ct), 256);
    check("freeze bad_bit_ct", 32'(a_bad_ct), 96);
    check("freeze last d_o", 32'(a_d_o), 32'h2);
    check("freeze last burst_o", 32'(a_burst_o), 0);
    check("freeze bl0 sym_ct", 32'(z_sym_ct), 256);
    check("freeze bl0 bad_bit_ct", 32'(z_bad_ct), 0);
    check("freeze bl0 d_o", 32'(z_d_o), 0);
    check("freeze bl10 err_o", 32'(c_err_o), 32'h2);
    check("freeze bl10 burst_o", 32'(c_burst_o), 1);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    check("post-freeze clear sym_ct", 32'(a_sym_ct), 0);
    check("post-freeze clear bad_bit_ct", 32'(a_bad_ct), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
